// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared types and encodings for the multicycle RV64I control unit.
//   state_e     : control FSM states (S_TRAP exists only with MC_ILLEGAL_TRAP_EN)
//   imm_fmt_e   : immediate format selected from the IR opcode
//   OP_*        : supported major opcodes
//   ASRC_*, BSRC_*, ALU_*, RES_* : datapath mux / ALU-op encodings
// Optional feature macro: MC_ILLEGAL_TRAP_EN
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ASRC_PC    = 2'b00;
  localparam logic [1:0] ASRC_OLDPC = 2'b01;
  localparam logic [1:0] ASRC_REGA  = 2'b10;

  localparam logic [1:0] BSRC_REGB  = 2'b00;
  localparam logic [1:0] BSRC_IMM   = 2'b01;
  localparam logic [1:0] BSRC_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_imm_gen.sv
// mc_imm_gen -- combinational immediate generator.
//   ir  : instruction register contents (32 bits)
//   imm : Nbits-wide immediate, sign-extended from ir[31]; I/S/B/J chosen by
//         opcode, zero for R-type and unsupported opcodes. B/J have bit0 = 0.
module mc_imm_gen
  import mc_ctrl_pkg::*;
#(
  parameter int Nbits = 64
) (
  input  logic [31:0]      ir,
  output logic [Nbits-1:0] imm
);

  imm_fmt_e fmt;

  always_comb begin
    fmt = IMM_NONE;
    case (ir[6:0])
      OP_LOAD, OP_IALU: fmt = IMM_I;
      OP_STORE:         fmt = IMM_S;
      OP_BRANCH:        fmt = IMM_B;
      OP_JAL:           fmt = IMM_J;
      default:          fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(Nbits-12){ir[31]}}, ir[31:20]};
      IMM_S: imm = {{(Nbits-12){ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: imm = {{(Nbits-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J: imm = {{(Nbits-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit -- multicycle RV64I control FSM with instruction register.
// Supports ld/sd, R-type, I-ALU, beq and jal; memory states stall on mem_ready.
// Ports:
//   clk, rst (sync, active-high)      instr, mem_ready, zero : inputs
//   r_reg1, r_reg2, w_reg, reg_we     : register-file addressing / write enable
//   imm, funct3, funct7_5             : decoded IR fields for the datapath
//   ir_we, pc_we, mem_we, adr_src     : IR/PC/memory control
//   alu_src_a, alu_src_b, alu_op, result_src : datapath selects
//   illegal                           : unknown-opcode trap flag
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds a sticky TRAP state;
// without it unknown opcodes execute as a NOP and illegal is tied 0).
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int          Nbits    = 64,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [4:0]       r_reg1,
  output logic [4:0]       r_reg2,
  output logic [4:0]       w_reg,
  output logic             reg_we,
  output logic [Nbits-1:0] imm,
  output logic [2:0]       funct3,
  output logic             funct7_5,
  output logic             ir_we,
  output logic             pc_we,
  output logic             mem_we,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal
);

  state_e      state;
  state_e      state_next;
  logic [31:0] ir;
  logic [6:0]  opcode;

  assign opcode   = ir[6:0];
  assign r_reg1   = ir[19:15];
  assign r_reg2   = ir[24:20];
  assign w_reg    = ir[11:7];
  assign funct3   = ir[14:12];
  assign funct7_5 = ir[30];

  mc_imm_gen #(
    .Nbits (Nbits)
  ) u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

  // IR is only written in FETCH on a completed read, so it stays stable
  // for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= NOP_INSN;
    end else begin
      state <= state_next;
      if (ir_we) ir <= instr;
    end
  end

  // Everything is held at zero while rst is high so no write can slip
  // through in the reset cycle, even from a stalled memory state.
  always_comb begin
    state_next = state;
    reg_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = ASRC_PC;
    alu_src_b  = BSRC_REGB;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    if (!rst) begin
      case (state)
        S_FETCH: begin
          alu_src_b  = BSRC_FOUR;
          result_src = RES_ALU;
          ir_we      = mem_ready;
          pc_we      = mem_ready;
          if (mem_ready) state_next = S_DECODE;
        end
        S_DECODE: begin
          // oldPC + imm: branch target parked in ALUOut
          alu_src_a = ASRC_OLDPC;
          alu_src_b = BSRC_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_RTYPE:          state_next = S_EXECR;
            OP_IALU:           state_next = S_EXECI;
            OP_BRANCH:         state_next = S_BEQ;
            OP_JAL:            state_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
            default:           state_next = S_TRAP;
`else
            default:           state_next = S_FETCH;
`endif
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = ASRC_REGA;
          alu_src_b  = BSRC_IMM;
          state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          if (mem_ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_we     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          adr_src = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) state_next = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a  = ASRC_REGA;
          alu_src_b  = BSRC_REGB;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a  = ASRC_REGA;
          alu_src_b  = BSRC_IMM;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_we     = 1'b1;
          state_next = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a  = ASRC_REGA;
          alu_src_b  = BSRC_REGB;
          alu_op     = ALU_SUB;
          result_src = RES_ALUOUT;
          pc_we      = zero;
          state_next = S_FETCH;
        end
        S_JAL: begin
          // PC <= target from ALUOut while the ALU forms oldPC+4 for rd
          alu_src_a  = ASRC_OLDPC;
          alu_src_b  = BSRC_FOUR;
          result_src = RES_ALUOUT;
          pc_we      = 1'b1;
          state_next = S_ALUWB;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal    = 1'b1;
          state_next = S_TRAP;
        end
`endif
        default: state_next = S_FETCH;
      endcase
    end
  end

`ifndef MC_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule
